// File: rtl/gray_sync_decoder.sv
// Receive-side decoder for a Gray count arriving from a foreign clock domain:
// synchronises it, decodes it to binary and classifies each change as up, down or jump.
module gray_sync_decoder #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     gray_in,
  input  logic             clr_fault,
  output logic [N-1:0]     gray_sync,
  output logic [N-1:0]     bin_out,
  output logic             up,
  output logic             down,
  output logic             fault,
  output logic [ERR_W-1:0] err_count,
  output logic             locked
);

  localparam int                FILL_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_STAGES + 1);

  localparam logic [1:0] INIT  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  logic [N-1:0]      sync_q [SYNC_STAGES];
  logic [N-1:0]      dec;
  logic [N-1:0]      bin_inc;
  logic [N-1:0]      bin_dec;
  logic              track_en;
  logic              is_up;
  logic              is_down;
  logic              is_jump;
  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;

  // Plain flop chain: gray_in is only ever sampled by stage 0, nothing sits between stages.
  // NOTE: the synchroniser array is reset like any other register so gray_sync is 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign gray_sync = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    dec = '0;
    for (int i = 0; i < N; i++) dec[i] = ^(gray_sync >> i);
  end

  assign bin_inc  = bin_out + N'(1);
  assign bin_dec  = bin_out - N'(1);
  assign track_en = (state != INIT);
  assign is_up    = track_en && (dec == bin_inc);
  assign is_down  = track_en && (dec == bin_dec);
  assign is_jump  = track_en && (dec != bin_out) && !is_up && !is_down;

  assign fill_next = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (fill_next == FILL_MAX) state_next = TRACK;
      TRACK:   if (is_jump) state_next = FAULT;
      FAULT:   if (clr_fault && !is_jump) state_next = TRACK;
      default: state_next = INIT;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      fill      <= '0;
      bin_out   <= '0;
      up        <= 1'b0;
      down      <= 1'b0;
      err_count <= '0;
    end else begin
      state   <= state_next;
      fill    <= fill_next;
      bin_out <= dec;
      up      <= is_up;
      down    <= is_down;
      if (is_jump && (err_count != '1)) err_count <= err_count + ERR_W'(1);
    end
  end

  assign fault  = (state == FAULT);
  assign locked = (state != INIT);

endmodule

// File: doc/gray_sync_decoder.md
# gray_sync_decoder

Receive-side companion to the Gray-coded counter. It takes a Gray count produced in another clock domain and synchronises it into `clk` through a flop chain. It then decodes the count to binary and classifies every change as up-step, down-step or illegal jump. Typical placement is the read side of an async FIFO pointer, or a position/count monitor crossing domains.

## Interface
Parameters:
- N, 4 — count width in bits (N ≥ 2).
- SYNC_STAGES, 2 — number of synchroniser flops (≥ 2).
- ERR_W, 8 — width of the saturating jump-error counter.

Ports:
- clk  input  1  receive-domain clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- gray_in  input  N  Gray count from the foreign domain; treated as asynchronous.
- clr_fault  input  1  synchronous pulse; clears the sticky fault.
- gray_sync  output  N  last synchroniser stage.
- bin_out  output  N  registered binary decode of gray_sync.
- up  output  1  one-cycle pulse: bin_out just advanced by +1 (mod 2^N).
- down  output  1  one-cycle pulse: bin_out just moved by −1 (mod 2^N).
- fault  output  1  sticky flag: an illegal jump has been detected.
- err_count  output  ERR_W  saturating count of illegal jumps.
- locked  output  1  high once the synchroniser is filled and tracking has started.

## Operation
- Synchroniser:
  - Stage 1 samples gray_in each edge; stage k samples stage k−1.
  - gray_sync is the last stage. No logic is placed between the stages.
- Decode (combinational, from gray_sync): b[N−1] = g[N−1]; b[i] = b[i+1] ^ g[i].
- bin_out loads the decode value every edge in every state except reset.
- Classification compares the decode value against the current bin_out:
  - equal → no event;
  - bin_out+1 mod 2^N → up;
  - bin_out−1 mod 2^N → down;
  - anything else → jump.
- up, down and jump are mutually exclusive. All are registered, so they appear in the same cycle as the new bin_out.
- A fill counter of width clog2(SYNC_STAGES+2) counts edges after reset release and saturates at SYNC_STAGES+1.
- State machine (states INIT, TRACK, FAULT):
  - INIT: no classification; up, down and jump are forced to 0. Go to TRACK on the edge where the fill count reaches SYNC_STAGES+1. locked goes high on that edge.
  - TRACK: classify every edge. On a jump go to FAULT, set fault=1 and increment err_count.
  - FAULT: keep classifying. up and down still pulse normally. Every further jump increments err_count.
    - clr_fault with no jump in the same cycle → TRACK, fault=0 on that edge.
    - clr_fault in the same cycle as a jump → stay in FAULT, fault stays 1, err_count increments.
  - clr_fault in INIT or TRACK has no effect.
- err_count saturates at 2^ERR_W−1 and is never wrapped. Only rst clears it; clr_fault does not.
- Wrap-around counts as a legal step: 2^N−1 → 0 is up, and 0 → 2^N−1 is down.

## Timing
- Reset values: all synchroniser flops 0, gray_sync=0, bin_out=0, up=0, down=0, fault=0, err_count=0, locked=0, state INIT, fill counter 0.
- Reset is asynchronous, so assertion mid-operation clears everything immediately. After release the full INIT fill sequence repeats.
- Latency, for gray_in stable before edge k:
  - gray_sync reflects it after edge k+SYNC_STAGES−1;
  - bin_out, up and down after edge k+SYNC_STAGES.
  - This is SYNC_STAGES+1 edges end to end (3 at default).
- locked rises on edge SYNC_STAGES+1 after reset release. The first classification happens on edge SYNC_STAGES+2.
- up, down and err_count increments last exactly one cycle per event. A constant input produces no pulses.
- Throughput: one legal step per clk cycle is classified correctly. Faster source changes may be seen as jumps, and this is the intended behaviour.

## Test plan
- **Reset and lock** (N=4, SYNC_STAGES=2): hold rst, then release with gray_in=0110 → all outputs 0 during reset; locked=1 and bin_out=4 after the 3rd edge; no up, down or fault at any point.
- **Up sweep:** step gray_in through Gray 0..15 and then 0 again, one value every 4 cycles → one up pulse per step, each 3 edges after the change; bin_out tracks 0..15,0; the 15→0 wrap (1000→0000) gives up; fault stays 0.
- **Down step:** with bin_out=0 settled, drive gray_in=1000 → down=1 for one cycle and bin_out=15, 3 edges later.
- **Jump:** go from gray 0001 (bin 1) to 0111 (bin 5) → fault=1, err_count=1, up=down=0, bin_out=5. Next step to gray 0101 (bin 6) → up pulses while fault stays 1.
- **Clear rules:**
  - Assert clr_fault in the same cycle that a jump (5→12) is classified → fault stays 1, err_count=2.
  - Then assert clr_fault alone → fault=0 on the next edge, err_count holds at 2.
- **Saturation and reset mid-run:**
  - Force 300 alternating jumps → err_count stops at 255.
  - Assert rst mid-stream → all outputs 0 at once. After release, locked=0 for 3 edges, and no events occur before edge 4.
